alu_slice_sequencer: RTL and testbench
======================================

// Module: alu_slice_sequencer
// PURPOSE
//  Multi-cycle front end for the 4-bit 74181-style alu slice. Accepts a WIDTH-bit
//  operation over a valid/ready request channel and drives the slice one nibble
//  per cycle, LSB first, chaining the slice carry through a register.
//  Collects the result, final carry and an all-nibbles compare flag, and returns
//  them on a valid/ready response channel. Sits directly upstream of alu; its
//  alu_*_o ports connect to the slice inputs and its alu_*_i ports to the slice outputs.
// PARAMETERS
//  WIDTH   16   operand/result width; must be a multiple of 4 (NIB = WIDTH/4, NIB >= 2)
// PORTS
//  clk_i           in   1      single clock; all state updates on rising edge
//  rst_i           in   1      synchronous, active-high reset
//  req_valid_i     in   1      request valid
//  req_ready_o     out  1      request ready (high only in IDLE)
//  req_mode_i      in   1      slice mode: 1 = logic, 0 = arithmetic
//  req_select_i    in   4      slice function select
//  req_a_i         in   WIDTH  operand A
//  req_b_i         in   WIDTH  operand B
//  req_carry_n_i   in   1      carry-in to nibble 0, active-low (0 = +1)
//  alu_mode_o      out  1      to slice mode_control_i
//  alu_select_o    out  4      to slice select_input_i
//  alu_a_o         out  4      to slice operand_a_i (current nibble)
//  alu_b_o         out  4      to slice operand_b_i (current nibble)
//  alu_carry_o     out  1      to slice carry_input_i (active-low)
//  alu_f_i         in   4      from slice function_output_o
//  alu_carry_i     in   1      from slice carry_output_o (active-low)
//  alu_cmp_i       in   1      from slice cmp_output_o
//  rsp_valid_o     out  1      response valid
//  rsp_ready_i     in   1      response ready
//  rsp_result_o    out  WIDTH  assembled result
//  rsp_carry_n_o   out  1      carry out of the top nibble, active-low
//  rsp_equal_o     out  1      AND of alu_cmp_i over all nibbles (A==B for sel=0110, mode=0, carry_n=1)
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. Nibble index idx is a counter of width clog2(NIB).
//  - Reset (or rst_i high in any state): state=IDLE, idx=0, rsp_valid_o=0,
//    rsp_result_o=0, rsp_carry_n_o=1, rsp_equal_o=0, operand/carry registers cleared
//    (carry reg=1). A reset mid-RUN or mid-DONE aborts the operation; no response is issued.
//  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch mode, select, A, B,
//    carry reg<=req_carry_n_i, equal reg<=1, idx<=0, then go to RUN.
//  - RUN: req_ready_o=0. The slice is combinational; drive alu_a_o=A[4*idx+:4],
//    alu_b_o=B[4*idx+:4], alu_carry_o=carry reg, alu_mode_o/alu_select_o=latched values.
//    Each cycle: result[4*idx+:4]<=alu_f_i; carry reg<=alu_carry_i;
//    equal reg<=equal reg & alu_cmp_i; idx<=idx+1.
//    When idx==NIB-1, go to DONE (idx wraps to 0).
//  - Outside RUN: alu_mode_o=1, alu_select_o=0, alu_a_o=0, alu_b_o=0, alu_carry_o=1.
//  - DONE: rsp_valid_o=1. rsp_result_o, rsp_carry_n_o and rsp_equal_o are registered
//    and hold stable while rsp_valid_o=1. On rsp_ready_i, go to IDLE; rsp_valid_o
//    drops on the next cycle. Outputs keep their last values until the next DONE.
//  - Latency: request accepted on edge E0. RUN occupies cycles 1..NIB.
//    rsp_valid_o rises after edge E(NIB) (NIB=4 gives 4 cycles).
//    The next request can be accepted one cycle after the response handshake. There is
//    no overlap, and req_ready_o is 0 while rsp_valid_o=1.
//  - req_valid_i and request data are ignored outside IDLE; there is no buffering.
//  - Mode=1 (logic): the carry chain is still registered, but the result is
//    carry-independent per the slice.
// TESTING
//  1. ADD sel=1001 mode=0 carry_n=1, A=0x1234 B=0x0FFF -> result 0x2233, carry_n_o=1.
//  2. ADD sel=1001 mode=0 carry_n=1, A=0xFFFF B=0x0001 -> result 0x0000, carry_n_o=0
//     (carry ripples through all 4 nibbles).
//  3. Compare sel=0110 mode=0 carry_n=1, A=B=0x5A5A -> result 0xFFFF, equal=1;
//     A=0x5A5B, B=0x5A5A -> equal=0. SUB with carry_n=0: 0x0010-0x0001 -> 0x000F.
//  4. Logic XOR sel=0110 mode=1, A=0xF0F0 B=0xFF00 -> 0x0FF0, independent of carry_n.
//  5. Handshake: accept at E0 -> rsp_valid_o high after E4. Hold rsp_ready_i=0 for
//     5 cycles -> response stable and req_ready_o=0 throughout. Then rsp_ready_i=1 ->
//     req_ready_o=1 on the following cycle.
//  6. Assert rst_i in the 2nd RUN cycle -> rsp_valid_o never rises, req_ready_o=1 the
//     cycle after reset deasserts, all outputs at their reset values.

Source files
------------

// File: rtl/alu_slice_sequencer_if.sv
// Request, slice-drive and response signals of the alu slice sequencer.
// The slave modport is the sequencer's view; master is the surrounding requester plus slice.
interface alu_slice_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_mode_i;
  logic [3:0]       req_select_i;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic             req_carry_n_i;

  logic             alu_mode_o;
  logic [3:0]       alu_select_o;
  logic [3:0]       alu_a_o;
  logic [3:0]       alu_b_o;
  logic             alu_carry_o;
  logic [3:0]       alu_f_i;
  logic             alu_carry_i;
  logic             alu_cmp_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_result_o;
  logic             rsp_carry_n_o;
  logic             rsp_equal_o;

  modport slave (
    input  req_valid_i, req_mode_i, req_select_i, req_a_i, req_b_i, req_carry_n_i,
    output req_ready_o,
    output alu_mode_o, alu_select_o, alu_a_o, alu_b_o, alu_carry_o,
    input  alu_f_i, alu_carry_i, alu_cmp_i,
    output rsp_valid_o, rsp_result_o, rsp_carry_n_o, rsp_equal_o,
    input  rsp_ready_i
  );

  modport master (
    output req_valid_i, req_mode_i, req_select_i, req_a_i, req_b_i, req_carry_n_i,
    input  req_ready_o,
    input  alu_mode_o, alu_select_o, alu_a_o, alu_b_o, alu_carry_o,
    output alu_f_i, alu_carry_i, alu_cmp_i,
    input  rsp_valid_o, rsp_result_o, rsp_carry_n_o, rsp_equal_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Drives a 4-bit 74181-style slice one nibble per cycle, LSB first, with a registered
// carry chain, and returns the assembled WIDTH-bit result over a valid/ready response.
module alu_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  alu_slice_sequencer_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             last_nib;
  logic             mode_q;
  logic [3:0]       sel_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, equal_q;
  logic [WIDTH-1:0] result_q;
  logic             rsp_carry_q, rsp_equal_q;

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = RUN;
      RUN:     if (last_nib)        state_d = DONE;
      DONE:    if (bus.rsp_ready_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    bus.req_ready_o  = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    bus.alu_mode_o   = 1'b1;
    bus.alu_select_o = 4'h0;
    bus.alu_a_o      = 4'h0;
    bus.alu_b_o      = 4'h0;
    bus.alu_carry_o  = 1'b1;
    case (state_q)
      IDLE: bus.req_ready_o = 1'b1;
      RUN: begin
        bus.alu_mode_o   = mode_q;
        bus.alu_select_o = sel_q;
        bus.alu_a_o      = a_q[4*idx_q +: 4];
        bus.alu_b_o      = b_q[4*idx_q +: 4];
        bus.alu_carry_o  = carry_q;
      end
      DONE: bus.rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Current nibble merged into the accumulator; also the final value on the last nibble.
  always_comb begin
    acc_d                 = acc_q;
    acc_d[4*idx_q +: 4]   = bus.alu_f_i;
  end

  // NOTE: operand registers are plain flops, not a memory, so they take the reset like all state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      mode_q      <= 1'b0;
      sel_q       <= 4'h0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b1;
      equal_q     <= 1'b0;
      result_q    <= '0;
      rsp_carry_q <= 1'b1;
      rsp_equal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          mode_q  <= bus.req_mode_i;
          sel_q   <= bus.req_select_i;
          a_q     <= bus.req_a_i;
          b_q     <= bus.req_b_i;
          carry_q <= bus.req_carry_n_i;
          equal_q <= 1'b1;
          acc_q   <= '0;
          idx_q   <= '0;
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= bus.alu_carry_i;
          equal_q <= equal_q & bus.alu_cmp_i;
          idx_q   <= last_nib ? '0 : idx_q + IDX_W'(1);
          // Response registers only change here, so they hold through DONE and after.
          if (last_nib) begin
            result_q    <= acc_d;
            rsp_carry_q <= bus.alu_carry_i;
            rsp_equal_q <= equal_q & bus.alu_cmp_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_result_o  = result_q;
  assign bus.rsp_carry_n_o = rsp_carry_q;
  assign bus.rsp_equal_o   = rsp_equal_q;
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: a behavioural 74181 slice closes the loop, fixed vectors
// and random operations are checked against a whole-width arithmetic reference.
module tb_alu_slice_sequencer;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();
  alu_slice_sequencer #(.WIDTH(WIDTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // 74181 slice, active-high data, active-low carries; A=B output is the AND of F.
  logic [3:0] s_t1, s_t2, s_f;
  logic [4:0] s_sum;
  always_comb begin
    s_t1  = bus.alu_a_o | (bus.alu_b_o & {4{bus.alu_select_o[0]}})
                        | (~bus.alu_b_o & {4{bus.alu_select_o[1]}});
    s_t2  = (bus.alu_a_o & ~bus.alu_b_o & {4{bus.alu_select_o[2]}})
          | (bus.alu_a_o &  bus.alu_b_o & {4{bus.alu_select_o[3]}});
    s_sum = {1'b0, s_t1} + {1'b0, s_t2} + {4'b0, ~bus.alu_carry_o};
    s_f   = bus.alu_mode_o ? ~(s_t1 ^ s_t2) : s_sum[3:0];
    bus.alu_f_i     = s_f;
    bus.alu_carry_i = ~s_sum[4];
    bus.alu_cmp_i   = &s_f;
  end

  // Whole-width reference: {carry_n, equal, result}.
  function automatic logic [WIDTH+1:0] ref_op(input logic mode, input logic [3:0] sel,
                                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cn);
    logic [WIDTH-1:0] t1, t2, f;
    logic [WIDTH:0]   sum;
    t1  = a | (b & {WIDTH{sel[0]}}) | (~b & {WIDTH{sel[1]}});
    t2  = (a & ~b & {WIDTH{sel[2]}}) | (a & b & {WIDTH{sel[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {{WIDTH{1'b0}}, ~cn};
    f   = mode ? ~(t1 ^ t2) : sum[WIDTH-1:0];
    return {~sum[WIDTH], &f, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic mode, input logic [3:0] sel, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cn,
                       output logic [WIDTH-1:0] res, output logic rcn, output logic req, output bit ok);
    int n;
    logic [3:0] a0, b0;
    ok = 1'b0;
    res = '0; rcn = 1'b1; req = 1'b0;
    n = 0;
    while (!bus.req_ready_o && n < 20) begin tick(); n++; end
    if (!bus.req_ready_o) begin check("req_ready timeout", 0, 1); return; end
    bus.req_mode_i = mode; bus.req_select_i = sel; bus.req_a_i = a; bus.req_b_i = b;
    bus.req_carry_n_i = cn; bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    a0 = a[3:0]; b0 = b[3:0];
    check("first run cycle {ready,mode,sel,a,b,carry}",
          {bus.req_ready_o, bus.alu_mode_o, bus.alu_select_o, bus.alu_a_o, bus.alu_b_o, bus.alu_carry_o},
          {1'b0, mode, sel, a0, b0, cn});
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin tick(); n++; end
    check("latency", n, NIB);
    if (!bus.rsp_valid_o) return;
    check("req_ready during response", bus.req_ready_o, 1'b0);
    res = bus.rsp_result_o; rcn = bus.rsp_carry_n_o; req = bus.rsp_equal_o;
    ok = 1'b1;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("after handshake {req_ready,rsp_valid}", {bus.req_ready_o, bus.rsp_valid_o}, 2'b10);
  endtask

  typedef struct {
    string            name;
    logic             mode;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a, b;
    logic             cn;
    logic [WIDTH-1:0] exp_res;
    logic             exp_cn;
    logic             exp_eq;
    bit               chk_cn;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [WIDTH-1:0] res, junk_a;
    logic             rcn, req;
    logic [WIDTH+1:0] exp;
    bit               ok, rose;
    logic             r_mode, r_cn;
    logic [3:0]       r_sel;
    logic [WIDTH-1:0] r_a, r_b;

    vecs[0] = '{"add 1234+0fff",   1'b0, 4'b1001, 16'h1234, 16'h0FFF, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"add ffff+0001",   1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"cmp equal",       1'b0, 4'b0110, 16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{"cmp unequal",     1'b0, 4'b0110, 16'h5A5B, 16'h5A5A, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"sub 0010-0001",   1'b0, 4'b0110, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"xor carry_n=1",   1'b1, 4'b0110, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"xor carry_n=0",   1'b1, 4'b0110, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b1, 1'b0, 1'b0};

    bus.req_valid_i = 1'b0; bus.req_mode_i = 1'b0; bus.req_select_i = 4'h0;
    bus.req_a_i = '0; bus.req_b_i = '0; bus.req_carry_n_i = 1'b1; bus.rsp_ready_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset {rdy,vld,res,cn,eq,mode,sel,a,b,c}",
          {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_carry_n_o, bus.rsp_equal_o,
           bus.alu_mode_o, bus.alu_select_o, bus.alu_a_o, bus.alu_b_o, bus.alu_carry_o},
          {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1});

    foreach (vecs[i]) begin
      do_op(vecs[i].mode, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cn, res, rcn, req, ok);
      if (ok) begin
        check({vecs[i].name, " result"}, res, vecs[i].exp_res);
        if (vecs[i].chk_cn) check({vecs[i].name, " carry_n"}, rcn, vecs[i].exp_cn);
        check({vecs[i].name, " equal"}, req, vecs[i].exp_eq);
        finish_rsp();
      end
    end

    // Back-pressure: response holds for 5 cycles while new requests are ignored.
    do_op(1'b0, 4'b1001, 16'h1234, 16'h0FFF, 1'b1, res, rcn, req, ok);
    if (ok) begin
      for (int c = 0; c < 5; c++) begin
        junk_a = 16'(c * 16'h1111);
        bus.req_valid_i = 1'b1; bus.req_a_i = junk_a; bus.req_b_i = 16'hFFFF;
        tick();
        check("hold {vld,rdy,res,cn,eq}",
              {bus.rsp_valid_o, bus.req_ready_o, bus.rsp_result_o, bus.rsp_carry_n_o, bus.rsp_equal_o},
              {1'b1, 1'b0, 16'h2233, 1'b1, 1'b0});
      end
      bus.req_valid_i = 1'b0;
      finish_rsp();
      check("result kept after release", bus.rsp_result_o, 16'h2233);
    end

    // Reset during the second RUN cycle aborts the operation.
    bus.req_mode_i = 1'b0; bus.req_select_i = 4'b1001; bus.req_a_i = 16'hABCD;
    bus.req_b_i = 16'h1111; bus.req_carry_n_i = 1'b1; bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort reset {rdy,vld,res,cn,eq,mode,sel,a,b,c}",
          {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_carry_n_o, bus.rsp_equal_o,
           bus.alu_mode_o, bus.alu_select_o, bus.alu_a_o, bus.alu_b_o, bus.alu_carry_o},
          {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1});
    rose = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.rsp_valid_o) rose = 1'b1;
    end
    check("no response after abort", rose, 1'b0);

    // Random operations against the whole-width reference.
    for (int k = 0; k < 40; k++) begin
      r_mode = 1'($urandom_range(0, 1));
      r_sel  = 4'($urandom_range(0, 15));
      r_a    = 16'($urandom);
      r_b    = (k % 8 == 0) ? r_a : 16'($urandom);
      r_cn   = 1'($urandom_range(0, 1));
      exp    = ref_op(r_mode, r_sel, r_a, r_b, r_cn);
      do_op(r_mode, r_sel, r_a, r_b, r_cn, res, rcn, req, ok);
      if (ok) begin
        check("random {cn,eq,result}", {rcn, req, res}, exp);
        finish_rsp();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
